// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the push-button debouncer.
//   - key_state_e : per-key debounce FSM encoding
//   - *_DEF       : default timing constants used by key_debounce and key_debounce_ch
package key_pkg;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    CHECK_PRESS   = 2'd1,
    PRESSED       = 2'd2,
    CHECK_RELEASE = 2'd3
  } key_state_e;

  localparam int DB_CYCLES_DEF     = 16;
  localparam int CNT_W_DEF         = 16;
  localparam int REPEAT_DELAY_DEF  = 64;
  localparam int REPEAT_PERIOD_DEF = 16;

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one button channel -- two-flop synchroniser, debounce FSM,
// stability counter and (with KEY_AUTOREPEAT_EN defined) a hold-to-repeat counter.
//
// Ports:
//   clk       in   system clock
//   Reset     in   synchronous, active-high reset
//   raw_key   in   asynchronous button line, active-high
//   key_level out  debounced level (registered)
//   key_pulse out  one-cycle pulse on accepted press / repeat (registered)
//
// Optional feature macro: KEY_AUTOREPEAT_EN (adds REPEAT_DELAY / REPEAT_PERIOD).
//
// state         | meaning
// --------------+-----------------------------------------------------------
// IDLE          | key released and stable
// CHECK_PRESS   | s2 went high, counting stable-high cycles before accepting
// PRESSED       | press accepted, level high (repeat timer runs here)
// CHECK_RELEASE | s2 went low, counting stable-low cycles before releasing
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic clk,
  input  logic Reset,
  input  logic raw_key,
  output logic key_level,
  output logic key_pulse
);

  // DB_CYCLES >= 2 and 2**CNT_W > DB_CYCLES are assumed; the counter stops at CNT_LAST.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             s2;

`ifdef KEY_AUTOREPEAT_EN
  // REPEAT_PERIOD <= REPEAT_DELAY is assumed so the reload value is non-negative.
  localparam int               RPT_W      = $clog2(REPEAT_DELAY) + 1;
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  assign s2 = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], raw_key};
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    // Cleared everywhere except while holding in PRESSED, so any exit restarts the delay.
    rpt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (s2) begin
          state_d = CHECK_PRESS;
          cnt_d   = '0;
        end
      end
      CHECK_PRESS: begin
        if (!s2) begin
          state_d = IDLE;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = PRESSED;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_d = CHECK_RELEASE;
          cnt_d   = '0;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (rpt_q == RPT_LAST) begin
          pulse_d = 1'b1;
          rpt_d   = RPT_RELOAD;
        end else begin
          rpt_d = rpt_q + RPT_W'(1);
        end
`endif
      end
      CHECK_RELEASE: begin
        if (s2) begin
          state_d = PRESSED;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = IDLE;
          level_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
`ifdef KEY_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign key_level = level_q;
  assign key_pulse = pulse_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: N_KEYS debounced push-button channels plus a press encoder.
//
// Ports:
//   clk       in   system clock
//   Reset     in   synchronous, active-high reset
//   raw_key   in   [N_KEYS] asynchronous button lines, active-high
//   key_level out  [N_KEYS] debounced levels
//   key_pulse out  [N_KEYS] one-cycle press pulses
//   key_valid out  OR of key_pulse
//   key_code  out  [2] lowest-numbered key with a pulse, 0 when none
//   key_multi out  more than one pulse this cycle
//
// Optional feature macro: KEY_AUTOREPEAT_EN (hold-to-repeat pulses).
module key_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] raw_key,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_pulse,
  output logic              key_valid,
  output logic [1:0]        key_code,
  output logic              key_multi
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES     (DB_CYCLES),
      .CNT_W         (CNT_W)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk       (clk),
      .Reset     (Reset),
      .raw_key   (raw_key[g]),
      .key_level (key_level[g]),
      .key_pulse (key_pulse[g])
    );
  end

  // Encoder is combinational from the pulse registers so it lines up with key_pulse.
  always_comb begin
    key_code = 2'd0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (key_pulse[i]) begin
        key_code = 2'(i);
      end
    end
  end

  assign key_valid = |key_pulse;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign key_multi = |(key_pulse & (key_pulse - N_KEYS'(1)));

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 4;

  logic         clk = 1'b0;
  logic         Reset;
  logic [N-1:0] raw_key;
  logic [N-1:0] key_level, key_pulse;
  logic         key_valid, key_multi;
  logic [1:0]   key_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_debounce #(
    .N_KEYS    (N),
    .DB_CYCLES (DB),
    .CNT_W     (16)
`ifdef KEY_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
`endif
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .raw_key   (raw_key),
    .key_level (key_level),
    .key_pulse (key_pulse),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_multi (key_multi)
  );

  // Reference model: a key's accepted level flips once the synchronised input has
  // disagreed with it on DB+1 consecutive samples; presses pulse, releases do not.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_pls;
  int           m_run [N];
  int           m_age [N];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic [N-1:0] raw);
    logic s;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_pls[k] = 0;
        m_run[k] = 0; m_age[k] = 0;
      end else begin
        s = m_s2[k];
        m_pls[k] = 1'b0;
        if (s != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == DB + 1) begin
            m_lvl[k] = s;
            m_run[k] = 0;
            m_age[k] = 0;
            if (s) m_pls[k] = 1'b1;
          end
        end else begin
`ifdef KEY_AUTOREPEAT_EN
          if (m_lvl[k]) begin
            if (m_run[k] == 0) begin
              m_age[k]++;
              if (m_age[k] >= RD && ((m_age[k] - RD) % RP) == 0) m_pls[k] = 1'b1;
            end else begin
              m_age[k] = 0;
            end
          end
`endif
          m_run[k] = 0;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = raw[k];
      end
    end
  endtask

  task automatic compare_model();
    logic [1:0] ecode;
    int         cnt;
    ecode = 2'd0;
    cnt   = 0;
    for (int k = N - 1; k >= 0; k--) if (m_pls[k]) ecode = 2'(k);
    for (int k = 0; k < N; k++) if (m_pls[k]) cnt++;
    chk("mdl_level", 32'(key_level), 32'(m_lvl));
    chk("mdl_pulse", 32'(key_pulse), 32'(m_pls));
    chk("mdl_valid", 32'(key_valid), 32'(cnt > 0));
    chk("mdl_code",  32'(key_code),  32'(ecode));
    chk("mdl_multi", 32'(key_multi), 32'(cnt > 1));
  endtask

  task automatic tick(input logic rst, input logic [N-1:0] raw);
    Reset   = rst;
    raw_key = raw;
    @(posedge clk);
    model_step(rst, raw);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] raw;
    logic [N-1:0] lvl;
    logic [N-1:0] pls;
    logic         vld;
    logic [1:0]   code;
    logic         mul;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [N-1:0] raw, input logic [N-1:0] lvl,
                     input logic [N-1:0] pls, input logic vld, input logic [1:0] code,
                     input logic mul, input int n);
    vec_t v;
    v.rst = rst; v.raw = raw; v.lvl = lvl; v.pls = pls; v.vld = vld; v.code = code; v.mul = mul;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  initial begin
    int npulse, pedge, extra, drops;
    int hold [N];
    logic [N-1:0] rnd_raw;
    int rq[$];
    int rexp[5];

    Reset   = 1'b1;
    raw_key = '0;

    // reset state, clean press on key 3, release, simultaneous 1+2,
    // short glitch, exactly-long-enough press
    add(1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 2);
    add(0, 4'h8, 4'h0, 4'h0, 0, 0, 0, 6);
    add(0, 4'h8, 4'h8, 4'h8, 1, 3, 0, 1);
    add(0, 4'h8, 4'h8, 4'h0, 0, 0, 0, 3);
    add(0, 4'h0, 4'h8, 4'h0, 0, 0, 0, 6);
    add(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 3);
    add(0, 4'h6, 4'h0, 4'h0, 0, 0, 0, 6);
    add(0, 4'h6, 4'h6, 4'h6, 1, 1, 1, 1);
    add(0, 4'h6, 4'h6, 4'h0, 0, 0, 0, 2);
    add(0, 4'h0, 4'h6, 4'h0, 0, 0, 0, 6);
    add(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 3);
    add(0, 4'h1, 4'h0, 4'h0, 0, 0, 0, 3);
    add(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 8);
    add(0, 4'h1, 4'h0, 4'h0, 0, 0, 0, 5);
    add(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1);
    add(0, 4'h0, 4'h1, 4'h1, 1, 0, 0, 1);
    add(0, 4'h0, 4'h1, 4'h0, 0, 0, 0, 4);
    add(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 3);

    foreach (vq[i]) begin
      tick(vq[i].rst, vq[i].raw);
      chk("tbl_level", 32'(key_level), 32'(vq[i].lvl));
      chk("tbl_pulse", 32'(key_pulse), 32'(vq[i].pls));
      chk("tbl_valid", 32'(key_valid), 32'(vq[i].vld));
      chk("tbl_code",  32'(key_code),  32'(vq[i].code));
      chk("tbl_multi", 32'(key_multi), 32'(vq[i].mul));
    end

    // bounce on key 0: 1,0,1 then hold
    npulse = 0; pedge = 0;
    for (int i = 1; i <= 14; i++) begin
      tick(0, (i == 2) ? 4'h0 : 4'h1);
      if (key_pulse[0]) begin
        npulse++;
        pedge = i;
        chk("bounce_code", 32'(key_code), 0);
      end
    end
    chk("bounce_npulse", npulse, 1);
    chk("bounce_edge", pedge, 9);
    for (int i = 0; i < 8; i++) tick(0, 4'h0);

    // release glitch on key 2, then a real release
    extra = 0; drops = 0;
    for (int i = 1; i <= 27; i++) begin
      tick(0, (i <= 9 || (i >= 12 && i <= 17)) ? 4'h4 : 4'h0);
      if (i == 7) chk("glitch_press_pulse", 32'(key_pulse), 4'h4);
      if (i >= 8 && key_pulse[2]) extra++;
      if (i >= 8 && i <= 23 && !key_level[2]) drops++;
      if (i == 24) chk("glitch_release_level", 32'(key_level[2]), 0);
    end
    chk("glitch_extra_pulses", extra, 0);
    chk("glitch_level_drops", drops, 0);
    for (int i = 0; i < 4; i++) tick(0, 4'h0);

    // reset in the middle of debouncing key 1 (cnt==2 after edge 5)
    for (int i = 1; i <= 5; i++) tick(0, 4'h2);
    for (int i = 0; i < 2; i++) begin
      tick(1, 4'h2);
      chk("rst_level", 32'(key_level), 0);
      chk("rst_pulse", 32'(key_pulse), 0);
      chk("rst_valid", 32'(key_valid), 0);
      chk("rst_code",  32'(key_code),  0);
      chk("rst_multi", 32'(key_multi), 0);
    end
    npulse = 0; pedge = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(0, 4'h2);
      if (key_pulse[1]) begin npulse++; pedge = i; end
    end
    chk("rst_npulse", npulse, 1);
    chk("rst_edge", pedge, 7);
    for (int i = 0; i < 8; i++) tick(0, 4'h0);

`ifdef KEY_AUTOREPEAT_EN
    // hold key 1 for 30 cycles: initial pulse at 7, repeats at 7+8, +12, +16, +20
    rexp = '{7, 15, 19, 23, 27};
    for (int i = 1; i <= 30; i++) begin
      tick(0, 4'h2);
      if (key_pulse[1]) rq.push_back(i);
    end
    chk("rpt_npulse", rq.size(), 5);
    for (int i = 0; i < 5; i++) if (i < rq.size()) chk("rpt_edge", rq[i], rexp[i]);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, 4'h0);
      if (key_pulse != 0) npulse++;
    end
    chk("rpt_stop", npulse, 0);
`endif

    // random run-length stimulus against the model
    rnd_raw = '0;
    for (int k = 0; k < N; k++) hold[k] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (hold[k] == 0) begin
          rnd_raw[k] = 1'($urandom_range(0, 1));
          hold[k]    = $urandom_range(1, (($urandom_range(0, 3) == 0) ? 40 : 8));
        end else begin
          hold[k]--;
        end
      end
      tick(($urandom_range(0, 199) == 0), rnd_raw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Upstream conditioner for the four push-button inputs that drive the Control segment-display controller.
- Synchronises the raw asynchronous button lines and debounces each one with a per-key state machine.
- Produces clean levels, one-cycle press pulses and a priority-encoded key code.
- The Control block consumes key_level (as I3..I0) or key_pulse/key_code directly.

Parameters:
- N_KEYS, 4, number of button channels.
- DB_CYCLES, 16, cycles a synchronised input must stay stable before a change is accepted; minimum 2.
- CNT_W, 16, width of the debounce counter; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- raw_key  input  N_KEYS  asynchronous button lines, active-high, bit i = key i.
- key_level  output  N_KEYS  debounced level per key.
- key_pulse  output  N_KEYS  one-cycle pulse on accepted press per key.
- key_valid  output  1  OR of key_pulse.
- key_code  output  2  index of lowest-numbered key with key_pulse high; 0 when key_valid=0.
- key_multi  output  1  more than one key_pulse bit high this cycle.

Behaviour:
- Single clock domain on clk. Reset is synchronous, active-high, sampled on rising clk.
- Reset values: all sync flops 0, all FSMs IDLE, counters 0; key_level, key_pulse, key_valid, key_code, key_multi all 0.
- Synchroniser: two flops per key, s1 <= raw_key, s2 <= s1. The FSM sees s2 only.
- Per-key FSM states and transitions:
  - IDLE: s2=1 -> CHECK_PRESS with cnt=0.
  - CHECK_PRESS: s2=0 -> IDLE with no output. Else cnt<DB_CYCLES-1 -> cnt++. Else (cnt==DB_CYCLES-1 and s2=1) -> PRESSED, key_level=1, key_pulse=1 for exactly one cycle.
  - PRESSED: s2=0 -> CHECK_RELEASE with cnt=0.
  - CHECK_RELEASE: s2=1 -> PRESSED, no pulse, level stays 1. Else cnt<DB_CYCLES-1 -> cnt++. Else -> IDLE with key_level=0. Releases never pulse.
- Press latency: edge 1 is the first rising edge sampling raw_key=1. s2 is set at edge 2, CHECK_PRESS is entered at edge 3, and key_pulse/key_level rise at edge DB_CYCLES+3. Release latency is identical.
- A glitch shorter than DB_CYCLES cycles at s2 never changes key_level.
- key_pulse, key_level and the FSMs are registered. key_valid, key_code and key_multi are combinational from the key_pulse registers, so they appear in the same cycle as the pulse.
- Simultaneous acceptance on several keys:
  - all corresponding key_pulse bits are high together;
  - key_code = lowest index;
  - key_multi = 1.
- Reset mid-operation: all keys return to IDLE at once and any in-flight pulse is cancelled. A key held through reset deassertion is re-debounced and yields exactly one pulse at edge DB_CYCLES+3 after reset release, counting edge 1 as the first edge with Reset=0.
- Counter never exceeds DB_CYCLES-1, so there is no wrap-around.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - adds parameters REPEAT_DELAY (default 64) and REPEAT_PERIOD (default 16), and a per-key repeat counter;
  - in PRESSED, once REPEAT_DELAY cycles have elapsed since entry, emit a key_pulse, then one every REPEAT_PERIOD cycles while the key stays in PRESSED;
  - the counter clears on any exit from PRESSED, so a bounce back from CHECK_RELEASE restarts the delay;
  - repeat pulses feed key_valid/key_code/key_multi like press pulses.
- Undefined: exactly one pulse per accepted press, and no repeat logic is synthesised.

Decomposition:
- Shared package key_pkg holds:
  - FSM state encoding (IDLE=2'd0, CHECK_PRESS=2'd1, PRESSED=2'd2, CHECK_RELEASE=2'd3);
  - default DB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD constants.
- Natural sub-module key_debounce_ch contains the synchroniser, FSM, counter and optional repeat logic for one key. It is instantiated N_KEYS times by a generate loop.
- The top level holds only the encoder logic (key_valid, key_code, key_multi).

Test Plan:
- Clean press, DB_CYCLES=4: raw_key=4'b1000 from edge 1 -> key_pulse=4'b1000 for one cycle after edge 7, key_code=3, key_valid=1, key_level[3]=1 thereafter, key_pulse low at edge 8.
- Bounce: raw_key[0] toggles 1,0,1 at one-cycle spacing, then holds -> no pulse until 4 stable s2 cycles, then exactly one pulse on key 0 and key_code=0.
- Release glitch: key 2 pressed, raw low for 2 cycles then high -> key_level[2] stays 1 and no new pulse. Then raw low for 10 cycles -> key_level[2]=0 at release edge+7, with no pulse.
- Simultaneous: raw_key=4'b0110 on the same edge -> key_pulse=4'b0110, key_code=1, key_multi=1.
- Reset mid-debounce: Reset=1 at the cycle cnt=2 with key held -> all outputs 0. After Reset=0, one pulse at edge 7.
- With KEY_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4, key 1 held 30 cycles -> initial pulse, then pulses at +8, +12, +16... cycles after entering PRESSED, stopping once the key leaves PRESSED.
